tft_rd_scheduler: RTL

Read-side burst scheduler between the SDRAM controller's read port and the TFT pixel FIFO. Each frame it walks the active frame-buffer bank, issuing SDRAM read bursts whenever the pixel FIFO has room. It restarts on every vertical sync and ping-pongs between two frame-buffer banks so the display never reads the frame currently being written. It also flags pixel FIFO underflow seen by the TFT driver.

---
 rtl/tft_rd_scheduler.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/tft_rd_scheduler.sv
// tft_rd_scheduler
// Read-side burst scheduler that feeds the TFT pixel FIFO from the SDRAM
// frame buffer. Each frame restarts at the base of the displayed bank on the
// vertical-sync falling edge. SDRAM read bursts are issued whenever the FIFO
// has room for a full burst. The displayed bank ping-pongs with the write
// bank once the writer reports a finished frame.
// BURST_LEN must lie in 2..1023 so that it fits the 10-bit burst length port.

module tft_rd_scheduler #(
    parameter int                BURST_LEN   = 256,
    parameter int                FRAME_WORDS = 384000,
    parameter int                FIFO_DEPTH  = 1024,
    parameter int                ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] BANK1_BASE  = 24'h100000
) (
    input  logic              clk_vga,
    input  logic              rst_n,
    input  logic              tft_vs,
    input  logic              tft_req,
    input  logic [10:0]       fifo_usedw,
    input  logic              wr_frame_done,
    output logic              rd_burst_req,
    output logic [ADDR_W-1:0] rd_burst_addr,
    output logic [9:0]        rd_burst_len,
    input  logic              rd_burst_ack,
    input  logic              rd_burst_done,
    output logic              fifo_clr,
    output logic              rd_bank,
    output logic              wr_bank,
    output logic              underflow
);

    // The words-left counter needs at least 11 bits so that BURST_LEN is
    // representable for the min() comparison, even for tiny frames.
    localparam int WL_BITS = $clog2(FRAME_WORDS + 1);
    localparam int WL_W    = (WL_BITS > 11) ? WL_BITS : 11;

    localparam logic [WL_W-1:0] FRAME_WL   = WL_W'(FRAME_WORDS);
    localparam logic [WL_W-1:0] BURST_WL   = WL_W'(BURST_LEN);
    localparam logic [9:0]      BURST_L10  = 10'(BURST_LEN);
    localparam logic [11:0]     FILL_LIMIT = 12'(FIFO_DEPTH - BURST_LEN);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        CHECK,
        REQ,
        WAIT_DONE,
        SETTLE,
        FRAME_END
    } state_t;

    state_t            state;
    logic              vs_q1;
    logic              vs_q2;
    logic              fs;
    logic              flush_second;
    logic              swap_pend;
    logic              restart_pend;
    logic [ADDR_W-1:0] addr;
    logic [WL_W-1:0]   words_left;
    logic              fifo_room;
    logic [9:0]        next_len;
    logic [ADDR_W-1:0] bank_base;

    // Frame start is a 1 -> 0 transition of the registered vertical sync.
    assign fs = vs_q2 & ~vs_q1;

    // Issue only when a whole burst is guaranteed to fit in the FIFO.
    assign fifo_room = ({1'b0, fifo_usedw} <= FILL_LIMIT);

    // The last burst of a frame may be shorter than BURST_LEN.
    assign next_len = (words_left < BURST_WL) ? words_left[9:0] : BURST_L10;

    assign bank_base = rd_bank ? BANK1_BASE : '0;
    assign wr_bank   = ~rd_bank;

    // Register the vertical sync so that the edge detector sees clean samples.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            vs_q1 <= 1'b0;
            vs_q2 <= 1'b0;
        end else begin
            vs_q1 <= tft_vs;
            vs_q2 <= vs_q1;
        end
    end

    // Main scheduler FSM with bank swap bookkeeping and underflow flag.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            flush_second  <= 1'b0;
            swap_pend     <= 1'b0;
            restart_pend  <= 1'b0;
            addr          <= '0;
            words_left    <= '0;
            rd_burst_req  <= 1'b0;
            rd_burst_addr <= '0;
            rd_burst_len  <= '0;
            fifo_clr      <= 1'b0;
            rd_bank       <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            // A finished write frame is remembered until the next flush
            // consumes it. A pulse landing on the first flush cycle is
            // consumed directly by the bank toggle below.
            if (state == FLUSH && !flush_second) begin
                swap_pend <= 1'b0;
            end else if (wr_frame_done) begin
                swap_pend <= 1'b1;
            end

            // The FIFO is being cleared during FLUSH and is idle before the
            // first frame, so an empty read only counts while streaming.
            if (state == FLUSH) begin
                underflow <= 1'b0;
            end else if (state != IDLE && tft_req && fifo_usedw == '0) begin
                underflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (fs) begin
                        state        <= FLUSH;
                        fifo_clr     <= 1'b1;
                        flush_second <= 1'b0;
                    end
                end

                FLUSH: begin
                    if (!flush_second) begin
                        if (swap_pend || wr_frame_done) begin
                            rd_bank <= ~rd_bank;
                        end
                        flush_second <= 1'b1;
                    end else begin
                        addr         <= bank_base;
                        words_left   <= FRAME_WL;
                        fifo_clr     <= 1'b0;
                        flush_second <= 1'b0;
                        restart_pend <= 1'b0;
                        state        <= CHECK;
                    end
                end

                CHECK: begin
                    if (fs) begin
                        state    <= FLUSH;
                        fifo_clr <= 1'b1;
                    end else if (words_left == '0) begin
                        state <= FRAME_END;
                    end else if (fifo_room) begin
                        rd_burst_addr <= addr;
                        rd_burst_len  <= next_len;
                        rd_burst_req  <= 1'b1;
                        state         <= REQ;
                    end
                end

                REQ: begin
                    if (fs) begin
                        restart_pend <= 1'b1;
                    end
                    if (rd_burst_ack) begin
                        rd_burst_req <= 1'b0;
                        addr         <= addr + ADDR_W'(rd_burst_len);
                        words_left   <= words_left - WL_W'(rd_burst_len);
                        state        <= rd_burst_done ? SETTLE : WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (fs) begin
                        restart_pend <= 1'b1;
                    end
                    if (rd_burst_done) begin
                        state <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (restart_pend || fs) begin
                        state    <= FLUSH;
                        fifo_clr <= 1'b1;
                    end else begin
                        state <= CHECK;
                    end
                end

                FRAME_END: begin
                    if (fs) begin
                        state    <= FLUSH;
                        fifo_clr <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
